// File: rtl/sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl
//
// Purpose:
//   Moves a fixed-size sprite horizontally once per video frame and turns the
//   VGA raster position into a sprite ROM word address. The position is
//   clamped to [X_MIN, X_MAX], and the sprite is mirrored when it faces left.
//   Animation state and frame select a 4096-word frame inside the ROM.
//   The pixel path is a two-stage pipeline that accepts one pixel per clock.
//
// Ports:
//   Clk          in   1   system clock
//   Reset        in   1   asynchronous, active-low reset (0 = reset)
//   frame_clk    in   1   vertical-sync-rate level, synchronous to Clk
//   state_in     in   8   animation state: 0 stand, 1 attack, 2 move-left,
//                         3 move-right; other values are treated as stand
//   frame_num    in   8   animation frame index, clamped per state
//   move_l       in   1   move-left request, sampled on a frame tick
//   move_r       in   1   move-right request, sampled on a frame tick
//   DrawX        in  10   current VGA column
//   DrawY        in  10   current VGA row
//   pos_x        out 10   sprite left column
//   facing_left  out  1   1 = sprite drawn mirrored
//   sprite_addr  out 17   sprite ROM word address (0 when not hit)
//   sprite_hit   out  1   current pixel (2 cycles earlier) lies in the sprite
// -----------------------------------------------------------------------------
module sprite_motion_ctrl #(
  parameter int X_INIT = 100,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 576,
  parameter int Y_POS  = 300,
  parameter int STEP   = 2,
  parameter int SPR_W  = 64,
  parameter int SPR_H  = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  state_in,
  input  logic [7:0]  frame_num,
  input  logic        move_l,
  input  logic        move_r,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [9:0]  pos_x,
  output logic        facing_left,
  output logic [16:0] sprite_addr,
  output logic        sprite_hit
);

  // Address layout: {frame_index, row, col}. Sprite dimensions are powers of
  // two, so the multiply-adds of the address reduce to a concatenation.
  localparam int COL_BITS   = $clog2(SPR_W);
  localparam int ROW_BITS   = $clog2(SPR_H);
  localparam int FRAME_BITS = 17 - COL_BITS - ROW_BITS;

  localparam logic [9:0]  X_INIT_V   = 10'(X_INIT);
  localparam logic [9:0]  X_MIN_V    = 10'(X_MIN);
  localparam logic [9:0]  X_MAX_V    = 10'(X_MAX);
  localparam logic [10:0] X_MAX_W    = 11'(X_MAX);
  localparam logic [9:0]  STEP_V     = 10'(STEP);
  localparam logic [10:0] STEP_W     = 11'(STEP);
  localparam logic [10:0] LEFT_LIM_W = 11'(X_MIN + STEP);
  localparam logic [10:0] SPR_W_W    = 11'(SPR_W);
  localparam logic [9:0]  Y_POS_V    = 10'(Y_POS);
  localparam logic [10:0] Y_END_W    = 11'(Y_POS + SPR_H);

  // ---------------------------------------------------------------------------
  // Frame tick: frame_clk is registered once; the rise is itself registered so
  // the tick is a clean one-cycle pulse one cycle after the rise.
  // ---------------------------------------------------------------------------
  logic frame_clk_reg;
  logic tick_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_clk_reg <= 1'b0;
      tick_reg      <= 1'b0;
    end else begin
      frame_clk_reg <= frame_clk;
      tick_reg      <= frame_clk & ~frame_clk_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Horizontal motion and facing direction
  // ---------------------------------------------------------------------------
  logic [9:0]  pos_x_reg, pos_x_next;
  logic        facing_reg, facing_next;
  logic [10:0] pos_ext;
  logic [10:0] pos_inc;
  logic [9:0]  pos_dec;

  always_comb begin
    pos_x_next  = pos_x_reg;
    facing_next = facing_reg;
    pos_ext     = {1'b0, pos_x_reg};
    // 11-bit increment so a step past X_MAX cannot wrap before the clamp.
    pos_inc     = pos_ext + STEP_W;
    pos_dec     = pos_x_reg - STEP_V;
    if (tick_reg) begin
      if (move_r && !move_l) begin
        pos_x_next  = (pos_inc > X_MAX_W) ? X_MAX_V : pos_inc[9:0];
        facing_next = 1'b0;
      end else if (move_l && !move_r) begin
        // Test before subtracting so the position never wraps below X_MIN.
        pos_x_next  = (pos_ext < LEFT_LIM_W) ? X_MIN_V : pos_dec;
        facing_next = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pos_x_reg  <= X_INIT_V;
      facing_reg <= 1'b0;
    end else begin
      pos_x_reg  <= pos_x_next;
      facing_reg <= facing_next;
    end
  end

  assign pos_x       = pos_x_reg;
  assign facing_left = facing_reg;

  // ---------------------------------------------------------------------------
  // Animation decode: per-state frame limit and base frame in the ROM.
  // Out-of-range states get limit 0 and base 0, i.e. stand frame 0.
  // ---------------------------------------------------------------------------
  logic [FRAME_BITS-1:0] limit_sel;
  logic [FRAME_BITS-1:0] base_sel;
  logic [FRAME_BITS-1:0] frame_sel;

  always_comb begin
    limit_sel = '0;
    base_sel  = '0;
    case (state_in)
      8'd0: begin limit_sel = FRAME_BITS'(7); base_sel = FRAME_BITS'(0);  end
      8'd1: begin limit_sel = FRAME_BITS'(8); base_sel = FRAME_BITS'(8);  end
      8'd2: begin limit_sel = FRAME_BITS'(4); base_sel = FRAME_BITS'(17); end
      8'd3: begin limit_sel = FRAME_BITS'(3); base_sel = FRAME_BITS'(22); end
      default: begin limit_sel = '0; base_sel = '0; end
    endcase
    frame_sel = (frame_num > 8'(limit_sel)) ? limit_sel
                                            : frame_num[FRAME_BITS-1:0];
  end

  // ---------------------------------------------------------------------------
  // Stage 1: offsets inside the sprite box and the in-box test. This stage
  // reads pos_x_reg, so a position update on the same edge does not disturb
  // the pixel being captured.
  // ---------------------------------------------------------------------------
  logic [9:0]  dx_next, dy_next;
  logic        in_box_next;
  logic [10:0] right_edge;

  always_comb begin
    dx_next     = DrawX - pos_x_reg;
    dy_next     = DrawY - Y_POS_V;
    right_edge  = pos_ext + SPR_W_W;
    in_box_next = (DrawX >= pos_x_reg) && ({1'b0, DrawX} < right_edge) &&
                  (DrawY >= Y_POS_V)   && ({1'b0, DrawY} < Y_END_W);
  end

  logic [9:0]            s1_dx_reg;
  logic [9:0]            s1_dy_reg;
  logic                  s1_in_box_reg;
  logic [FRAME_BITS-1:0] s1_frame_reg;
  logic [FRAME_BITS-1:0] s1_base_reg;
  logic                  s1_flip_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_dx_reg     <= '0;
      s1_dy_reg     <= '0;
      s1_in_box_reg <= 1'b0;
      s1_frame_reg  <= '0;
      s1_base_reg   <= '0;
      s1_flip_reg   <= 1'b0;
    end else begin
      s1_dx_reg     <= dx_next;
      s1_dy_reg     <= dy_next;
      s1_in_box_reg <= in_box_next;
      s1_frame_reg  <= frame_sel;
      s1_base_reg   <= base_sel;
      s1_flip_reg   <= facing_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: ROM address. Mirroring is (SPR_W-1) - dx, which for a power-of-
  // two width is a bitwise inversion of the column offset.
  // ---------------------------------------------------------------------------
  logic [COL_BITS-1:0]   col;
  logic [FRAME_BITS-1:0] frame_index;
  logic                  hit_next;
  logic [16:0]           addr_next;

  genvar gi;
  generate
    for (gi = 0; gi < COL_BITS; gi = gi + 1) begin : g_col_mirror
      assign col[gi] = s1_dx_reg[gi] ^ s1_flip_reg;
    end
  endgenerate

  always_comb begin
    frame_index = s1_base_reg + s1_frame_reg;
    // Upper offset bits are always zero inside the box; folding them in keeps
    // the address confined to the sprite window even if that ever changed.
    hit_next    = s1_in_box_reg &&
                  (s1_dx_reg[9:COL_BITS] == '0) &&
                  (s1_dy_reg[9:ROW_BITS] == '0);
    addr_next   = '0;
    if (hit_next) begin
      addr_next = {frame_index, s1_dy_reg[ROW_BITS-1:0], col};
    end
  end

  logic [16:0] sprite_addr_reg;
  logic        sprite_hit_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sprite_addr_reg <= '0;
      sprite_hit_reg  <= 1'b0;
    end else begin
      sprite_addr_reg <= addr_next;
      sprite_hit_reg  <= hit_next;
    end
  end

  assign sprite_addr = sprite_addr_reg;
  assign sprite_hit  = sprite_hit_reg;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion_ctrl
//
// Directed bench for sprite_motion_ctrl. A second instance starts at x = 1 so
// the odd-position clamp cases (1 -> 0, 575 -> 576) are reachable with STEP=2.
// Both instances share all stimulus.
// -----------------------------------------------------------------------------
module tb_sprite_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_clk;
  logic        move_l;
  logic        move_r;
  logic [7:0]  state_in;
  logic [7:0]  frame_num;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;

  logic [9:0]  pos_x, pos_x_o;
  logic        facing_left, facing_left_o;
  logic [16:0] sprite_addr, sprite_addr_o;
  logic        sprite_hit, sprite_hit_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .frame_clk   (frame_clk),
    .state_in    (state_in),
    .frame_num   (frame_num),
    .move_l      (move_l),
    .move_r      (move_r),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .pos_x       (pos_x),
    .facing_left (facing_left),
    .sprite_addr (sprite_addr),
    .sprite_hit  (sprite_hit)
  );

  sprite_motion_ctrl #(.X_INIT(1)) dut_odd (
    .Clk         (clk),
    .Reset       (rst_n),
    .frame_clk   (frame_clk),
    .state_in    (state_in),
    .frame_num   (frame_num),
    .move_l      (move_l),
    .move_r      (move_r),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .pos_x       (pos_x_o),
    .facing_left (facing_left_o),
    .sprite_addr (sprite_addr_o),
    .sprite_hit  (sprite_hit_o)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One frame tick with the given move requests; frame_clk is held high for
  // three cycles so a second tick from the same rise would be visible.
  task automatic do_tick(input logic l, input logic r);
    @(negedge clk);
    move_l    = l;
    move_r    = r;
    frame_clk = 1'b1;
    repeat (3) @(negedge clk);
    frame_clk = 1'b0;
    @(negedge clk);
  endtask

  // Pixel vector table: state, frame, x, y, expected hit, expected address.
  int vs[16], vf[16], vx[16], vy[16], eh[16], ea[16];
  int nvec;

  task automatic add_vec(input int s, input int f, input int x, input int y,
                         input int h, input int a);
    vs[nvec] = s; vf[nvec] = f; vx[nvec] = x; vy[nvec] = y;
    eh[nvec] = h; ea[nvec] = a;
    nvec++;
  endtask

  // Back-to-back pixels, one per cycle; results checked two cycles later.
  task automatic run_stream(input string name);
    for (int i = 0; i < nvec + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check_eq($sformatf("%s%0d_hit", name, i - 2), int'(sprite_hit), eh[i-2]);
        check_eq($sformatf("%s%0d_addr", name, i - 2), int'(sprite_addr), ea[i-2]);
      end
      if (i < nvec) begin
        state_in  = 8'(vs[i]);
        frame_num = 8'(vf[i]);
        draw_x    = 10'(vx[i]);
        draw_y    = 10'(vy[i]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    frame_clk = 1'b0;
    move_l    = 1'b0;
    move_r    = 1'b0;
    state_in  = 8'd0;
    frame_num = 8'd0;
    draw_x    = 10'd0;
    draw_y    = 10'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_pos", int'(pos_x), 100);
    check_eq("rst_face", int'(facing_left), 0);
    check_eq("rst_addr", int'(sprite_addr), 0);
    check_eq("rst_hit", int'(sprite_hit), 0);
    check_eq("rst_pos_odd", int'(pos_x_o), 1);
    check_eq("rst_addr_odd", int'(sprite_addr_o), 0);
    check_eq("rst_hit_odd", int'(sprite_hit_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_pos", int'(pos_x), 100);

    // Address path at pos_x=100, facing right
    nvec = 0;
    add_vec(1, 2,   110, 305, 1, 41290);
    add_vec(3, 9,   110, 305, 1, 102730);
    add_vec(7, 5,   110, 305, 1, 330);
    add_vec(1, 2,   164, 305, 0, 0);
    add_vec(1, 2,   163, 305, 1, 41343);
    add_vec(0, 2,   100, 300, 1, 8192);
    add_vec(0, 2,    99, 300, 0, 0);
    add_vec(2, 6,   120, 363, 1, 90068);
    add_vec(2, 1,   120, 364, 0, 0);
    add_vec(1, 9,   101, 299, 0, 0);
    add_vec(0, 200, 105, 310, 1, 29317);
    run_stream("fr");

    // Pixel captured on the same edge as a move: uses pre-update pos_x=100
    @(negedge clk);
    move_l = 1'b0; move_r = 1'b1; frame_clk = 1'b1;
    @(negedge clk);
    state_in = 8'd0; frame_num = 8'd0; draw_x = 10'd101; draw_y = 10'd300;
    @(negedge clk);
    @(negedge clk);
    check_eq("sameedge_hit", int'(sprite_hit), 1);
    check_eq("sameedge_addr", int'(sprite_addr), 1);
    frame_clk = 1'b0;
    check_eq("tick1_pos", int'(pos_x), 102);
    @(negedge clk);

    // Remaining right ticks: 104..110
    for (int k = 1; k <= 4; k++) begin
      do_tick(1'b0, 1'b1);
      check_eq($sformatf("right%0d_pos", k), int'(pos_x), 102 + 2 * k);
      check_eq($sformatf("right%0d_face", k), int'(facing_left), 0);
    end

    // Left ticks back to 100, facing left
    for (int k = 1; k <= 5; k++) begin
      do_tick(1'b1, 1'b0);
      check_eq($sformatf("left%0d_pos", k), int'(pos_x), 110 - 2 * k);
      check_eq($sformatf("left%0d_face", k), int'(facing_left), 1);
      check_eq($sformatf("left%0d_pos_odd", k), int'(pos_x_o), 11 - 2 * k);
    end

    // Mirrored address path at pos_x=100
    nvec = 0;
    add_vec(1, 2, 110, 305, 1, 41333);
    add_vec(3, 1, 100, 300, 1, 94271);
    add_vec(0, 0, 163, 363, 1, 4032);
    run_stream("fl");

    // Left clamp on the odd instance: 1 -> 0 -> 0
    do_tick(1'b1, 1'b0);
    check_eq("lclamp1_pos_odd", int'(pos_x_o), 0);
    check_eq("lclamp1_face_odd", int'(facing_left_o), 1);
    check_eq("lclamp1_pos", int'(pos_x), 98);
    do_tick(1'b1, 1'b0);
    check_eq("lclamp2_pos_odd", int'(pos_x_o), 0);
    check_eq("lclamp2_pos", int'(pos_x), 96);

    // Reset pulse, then run right up to the clamp
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check_eq("rerst_pos", int'(pos_x), 100);
    check_eq("rerst_pos_odd", int'(pos_x_o), 1);
    check_eq("rerst_face", int'(facing_left), 0);
    for (int k = 0; k < 286; k++) do_tick(1'b0, 1'b1);
    do_tick(1'b0, 1'b1);
    check_eq("r575_pos_odd", int'(pos_x_o), 575);
    check_eq("r575_pos", int'(pos_x), 576);
    do_tick(1'b0, 1'b1);
    check_eq("rclamp1_pos_odd", int'(pos_x_o), 576);
    do_tick(1'b0, 1'b1);
    check_eq("rclamp2_pos_odd", int'(pos_x_o), 576);
    check_eq("rclamp2_pos", int'(pos_x), 576);
    do_tick(1'b1, 1'b1);
    check_eq("both1_pos", int'(pos_x), 576);
    check_eq("both1_face", int'(facing_left), 0);
    do_tick(1'b1, 1'b0);
    check_eq("l574_pos", int'(pos_x), 574);
    check_eq("l574_face", int'(facing_left), 1);
    do_tick(1'b1, 1'b1);
    check_eq("both2_pos", int'(pos_x), 574);
    check_eq("both2_face", int'(facing_left), 1);

    // Reset mid-stream with frame_clk held high
    @(negedge clk);
    move_l = 1'b0; move_r = 1'b1; frame_clk = 1'b1;
    state_in = 8'd1; frame_num = 8'd2; draw_x = 10'd600; draw_y = 10'd305;
    @(posedge clk);
    @(posedge clk);
    #2;
    check_eq("pre_rst_hit", int'(sprite_hit), 1);
    check_eq("pre_rst_addr", int'(sprite_addr), 41317);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_pos", int'(pos_x), 100);
    check_eq("mid_rst_face", int'(facing_left), 0);
    check_eq("mid_rst_hit", int'(sprite_hit), 0);
    check_eq("mid_rst_addr", int'(sprite_addr), 0);
    check_eq("mid_rst_pos_odd", int'(pos_x_o), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel1_pos", int'(pos_x), 100);
    check_eq("rel1_pos_odd", int'(pos_x_o), 1);
    check_eq("rel1_hit", int'(sprite_hit), 0);
    check_eq("rel1_addr", int'(sprite_addr), 0);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
